// File: rtl/aes_fifo_ctl_pkg.sv
// Shared encodings and layout constants for the AES block FIFO write scheduler.
// The header-word layout is only used when AES_FIFO_HDR_WORD_EN is defined.
package aes_fifo_ctl_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } sched_state_e;

   localparam int DSIZE_DEF = 32;
   localparam int BSIZE_DEF = 128;
   localparam int SEQW_DEF  = 8;

   // Header word: source id in the MSB, sequence number starting at bit 16.
   localparam int HDR_SEQ_LSB = 16;
   localparam int HDR_ID_PAD  = 7;

   function automatic int calc_nwords(input int bsize, input int dsize);
      return bsize / dsize;
   endfunction

endpackage

// File: rtl/aes_fifo_wr_sched_rr_arb2.sv
// Two-request round-robin arbiter; the owner holds the last-grant state.
// On contention the requester that did not win last time is granted.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = last ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/aes_fifo_wr_sched.sv
// Round-robin write scheduler serialising 128-bit AES blocks into a 32-bit async FIFO.
// Define AES_FIFO_HDR_WORD_EN to prefix every block with a source/sequence header word.
module aes_fifo_wr_sched
   import aes_fifo_ctl_pkg::*;
#(
   parameter int DSIZE  = DSIZE_DEF,
   parameter int BSIZE  = BSIZE_DEF,
   parameter int NWORDS = calc_nwords(BSIZE, DSIZE),
   parameter int SEQW   = SEQW_DEF
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             req0_valid,
   input  logic [BSIZE-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [BSIZE-1:0] req1_data,
   output logic             req1_ready,
   input  logic             wfull,
   output logic             winc,
   output logic [DSIZE-1:0] wdata,
   output logic             busy,
   output logic             grant_id
);

   localparam int CNTW = $clog2(NWORDS + 1);
`ifdef AES_FIFO_HDR_WORD_EN
   localparam int DATA_OFS = 1;
`else
   localparam int DATA_OFS = 0;
`endif
   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NWORDS - 1 + DATA_OFS);

   if ((BSIZE % DSIZE) != 0 || NWORDS != BSIZE / DSIZE ||
       HDR_SEQ_LSB + SEQW > DSIZE - 1 - HDR_ID_PAD + 1) begin : g_cfg_err
      $error("aes_fifo_wr_sched: inconsistent DSIZE/BSIZE/NWORDS/SEQW");
   end

   sched_state_e     state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [BSIZE-1:0] shadow_q, shadow_d;
   logic             grant_id_q, grant_id_d;
   logic             rr_last_q, rr_last_d;
   logic [1:0]       gnt;

   rr_arb2 u_arb (
      .req  ({req1_valid, req0_valid}),
      .last (rr_last_q),
      .gnt  (gnt)
   );

   // Ready is suppressed while reset is asserted so no handshake can be claimed
   // by a source when the registers cannot capture it.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      grant_id_d = grant_id_q;
      rr_last_d  = rr_last_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      winc       = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = wrst_n & gnt[0];
            req1_ready = wrst_n & gnt[1];
            if (gnt != 2'b00) begin
               shadow_d   = gnt[1] ? req1_data : req0_data;
               grant_id_d = gnt[1];
               rr_last_d  = gnt[1];
               cnt_d      = '0;
               state_d    = SEND;
            end
         end
         SEND: begin
            winc = !wfull;
            if (!wfull) begin
               if (cnt_q == LAST_CNT) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shadow_q   <= '0;
         grant_id_q <= 1'b0;
         rr_last_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         grant_id_q <= grant_id_d;
         rr_last_q  <= rr_last_d;
      end
   end

`ifdef AES_FIFO_HDR_WORD_EN
   logic [SEQW-1:0] seq0_q, seq1_q;

   // A source's sequence number advances once its final data word is in the FIFO.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         seq0_q <= '0;
         seq1_q <= '0;
      end else if (winc && cnt_q == LAST_CNT) begin
         if (grant_id_q) begin
            seq1_q <= seq1_q + SEQW'(1);
         end else begin
            seq0_q <= seq0_q + SEQW'(1);
         end
      end
   end
`endif

   always_comb begin
      wdata = '0;
`ifdef AES_FIFO_HDR_WORD_EN
      if (cnt_q == '0) begin
         wdata[DSIZE-1]              = grant_id_q;
         wdata[HDR_SEQ_LSB +: SEQW]  = grant_id_q ? seq1_q : seq0_q;
      end
`endif
      for (int i = 0; i < NWORDS; i++) begin
         if (cnt_q == CNTW'(i + DATA_OFS)) begin
            wdata = shadow_q[BSIZE-1-i*DSIZE -: DSIZE];
         end
      end
   end

   assign busy     = (state_q == SEND);
   assign grant_id = grant_id_q;

endmodule

// File: tb/tb_aes_fifo_wr_sched.sv
// Self-checking bench for aes_fifo_wr_sched: directed scenarios plus a randomized run
// against a word-queue reference model. Honours AES_FIFO_HDR_WORD_EN when defined.
module tb_aes_fifo_wr_sched;

   localparam int DW = 32;
   localparam int BW = 128;
   localparam int NW = 4;
`ifdef AES_FIFO_HDR_WORD_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif
   localparam int NWT = NW + HDR;

   logic          wclk;
   logic          wrst_n;
   logic          req0_valid, req1_valid;
   logic [BW-1:0] req0_data, req1_data;
   logic          req0_ready, req1_ready;
   logic          wfull;
   logic          winc;
   logic [DW-1:0] wdata;
   logic          busy;
   logic          grant_id;

   int checks = 0;
   int errors = 0;

   aes_fifo_wr_sched dut (
      .wclk       (wclk),
      .wrst_n     (wrst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .wfull      (wfull),
      .winc       (winc),
      .wdata      (wdata),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   initial begin
      wclk = 1'b0;
      forever #5 wclk = ~wclk;
   end

   // Word k of a block as it should appear on the FIFO write port.
   function automatic logic [DW-1:0] exp_word(input logic src, input logic [BW-1:0] blk,
                                              input logic [7:0] seq, input int k);
      logic [DW-1:0] hdr;
      hdr = {src, 7'b0, seq, 16'h0000};
      if (HDR == 1 && k == 0) return hdr;
      return blk[BW-1-(k-HDR)*DW -: DW];
   endfunction

   function automatic logic [BW-1:0] rand_blk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic apply_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = '0;
      req1_data  = '0;
      wfull      = 1'b0;
      wrst_n     = 1'b0;
      repeat (2) @(posedge wclk);
      @(negedge wclk);
      wrst_n = 1'b1;
      @(posedge wclk);
      #1;
   endtask

   task automatic test_reset();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_data  = rand_blk();
      req1_data  = rand_blk();
      wfull      = 1'b0;
      wrst_n     = 1'b0;
      @(posedge wclk);
      #1;
      checks++; if (winc !== 1'b0) begin errors++; $display("[TB] FAIL reset_winc: got %b expected 0", winc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (grant_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant_id: got %b expected 0", grant_id); end
      checks++; if (wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 00000000", wdata); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready}); end
      @(negedge wclk);
      wrst_n = 1'b1;
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL reset_first_winner: got %b expected 01", {req1_ready, req0_ready}); end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_single_block();
      logic [BW-1:0] blk;
      apply_reset();
      blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      req0_valid = 1'b1;
      req0_data  = blk;
      @(negedge wclk);
      checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL single_ready: got %b expected 01", {req1_ready, req0_ready}); end
      @(posedge wclk);
      #1;
      req0_valid = 1'b0;
      for (int k = 0; k < NWT; k++) begin
         @(negedge wclk);
         checks++; if (winc !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_winc[%0d]: got winc=%b busy=%b expected 1 1", k, winc, busy); end
         checks++; if (wdata !== exp_word(1'b0, blk, 8'h00, k)) begin errors++; $display("[TB] FAIL single_wdata[%0d]: got %h expected %h", k, wdata, exp_word(1'b0, blk, 8'h00, k)); end
         checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_in_send[%0d]: got %b expected 0", k, req0_ready); end
      end
      @(negedge wclk);
      checks++; if (busy !== 1'b0 || winc !== 1'b0) begin errors++; $display("[TB] FAIL single_done: got busy=%b winc=%b expected 0 0", busy, winc); end
   endtask

   task automatic test_contention();
      logic [BW-1:0] blka, blkb;
      logic [DW-1:0] stream[$];
      int order[4] = '{0, 1, 0, 1};
      int gi, wi;
      apply_reset();
      blka = rand_blk();
      blkb = rand_blk();
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < NWT; k++) begin
            stream.push_back(exp_word(order[b] == 1, (order[b] == 1) ? blkb : blka, 8'(b / 2), k));
         end
      end
      req0_valid = 1'b1;
      req0_data  = blka;
      req1_valid = 1'b1;
      req1_data  = blkb;
      gi = 0;
      wi = 0;
      for (int cyc = 0; cyc < 4 * (NWT + 1) + 8 && wi < 4 * NWT; cyc++) begin
         @(negedge wclk);
         if (req0_ready || req1_ready) begin
            checks++;
            if (gi >= 4 || {req1_ready, req0_ready} !== ((order[gi] == 1) ? 2'b10 : 2'b01)) begin
               errors++; $display("[TB] FAIL contention_grant[%0d]: got %b", gi, {req1_ready, req0_ready});
            end
            gi++;
         end
         if (winc) begin
            checks++;
            if (wdata !== stream[wi]) begin errors++; $display("[TB] FAIL contention_word[%0d]: got %h expected %h", wi, wdata, stream[wi]); end
            wi++;
         end
      end
      checks++; if (wi != 4 * NWT || gi != 4) begin errors++; $display("[TB] FAIL contention_count: got words=%0d grants=%0d expected %0d 4", wi, gi, 4 * NWT); end
      @(posedge wclk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [BW-1:0] blk;
      apply_reset();
      blk = rand_blk();
      req1_valid = 1'b1;
      req1_data  = blk;
      @(negedge wclk);
      checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("[TB] FAIL bp_ready: got %b expected 10", {req1_ready, req0_ready}); end
      @(posedge wclk);
      #1;
      req1_valid = 1'b0;
      wfull = 1'b1;
      repeat (10) begin
         @(negedge wclk);
         checks++; if (winc !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall: got winc=%b busy=%b expected 0 1", winc, busy); end
         checks++; if (wdata !== exp_word(1'b1, blk, 8'h00, 0)) begin errors++; $display("[TB] FAIL bp_hold: got %h expected %h", wdata, exp_word(1'b1, blk, 8'h00, 0)); end
      end
      @(posedge wclk);
      #1;
      wfull = 1'b0;
      for (int k = 0; k < NWT; k++) begin
         @(negedge wclk);
         checks++; if (winc !== 1'b1 || wdata !== exp_word(1'b1, blk, 8'h00, k)) begin errors++; $display("[TB] FAIL bp_word[%0d]: got winc=%b %h expected 1 %h", k, winc, wdata, exp_word(1'b1, blk, 8'h00, k)); end
         checks++; if (grant_id !== 1'b1) begin errors++; $display("[TB] FAIL bp_grant_id: got %b expected 1", grant_id); end
      end
      @(negedge wclk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_done: got busy=%b expected 0", busy); end
   endtask

   task automatic test_wfull_toggle();
      logic [BW-1:0] blk;
      int n;
      apply_reset();
      blk = rand_blk();
      req0_valid = 1'b1;
      req0_data  = blk;
      @(negedge wclk);
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL toggle_ready: got %b expected 1", req0_ready); end
      @(posedge wclk);
      #1;
      req0_valid = 1'b0;
      n = 0;
      for (int cyc = 0; cyc < 3 * NWT + 4; cyc++) begin
         wfull = (cyc % 2 == 0);
         @(negedge wclk);
         checks++; if (winc && wfull) begin errors++; $display("[TB] FAIL toggle_gating[%0d]: got winc=1 expected 0 while full", cyc); end
         if (winc) begin
            checks++;
            if (n >= NWT || wdata !== exp_word(1'b0, blk, 8'h00, n)) begin errors++; $display("[TB] FAIL toggle_word[%0d]: got %h", n, wdata); end
            n++;
         end
         @(posedge wclk);
         #1;
      end
      wfull = 1'b0;
      checks++; if (n != NWT) begin errors++; $display("[TB] FAIL toggle_count: got %0d expected %0d", n, NWT); end
   endtask

   task automatic test_reset_midblock();
      logic [BW-1:0] blk, blk2;
      apply_reset();
      blk  = rand_blk();
      blk2 = rand_blk();
      req0_valid = 1'b1;
      req0_data  = blk;
      @(negedge wclk);
      @(posedge wclk);
      #1;
      req0_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge wclk);
         checks++; if (winc !== 1'b1 || wdata !== exp_word(1'b0, blk, 8'h00, k)) begin errors++; $display("[TB] FAIL midrst_word[%0d]: got winc=%b %h", k, winc, wdata); end
      end
      @(posedge wclk);
      #1;
      req0_valid = 1'b1;
      req0_data  = blk2;
      req1_valid = 1'b1;
      req1_data  = rand_blk();
      wrst_n = 1'b0;
      #1;
      checks++; if (winc !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_async: got winc=%b busy=%b expected 0 0", winc, busy); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_ready: got %b expected 00", {req1_ready, req0_ready}); end
      @(negedge wclk);
      wrst_n = 1'b1;
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("[TB] FAIL midrst_winner: got %b expected 01", {req1_ready, req0_ready}); end
      @(posedge wclk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge wclk);
      checks++; if (winc !== 1'b1 || wdata !== exp_word(1'b0, blk2, 8'h00, 0)) begin errors++; $display("[TB] FAIL midrst_restart: got winc=%b %h expected 1 %h", winc, wdata, exp_word(1'b0, blk2, 8'h00, 0)); end
   endtask

`ifdef AES_FIFO_HDR_WORD_EN
   task automatic test_header();
      logic [DW-1:0] hdr_exp[2] = '{32'h8000_0000, 32'h8001_0000};
      logic [BW-1:0] blk;
      apply_reset();
      for (int b = 0; b < 2; b++) begin
         blk = rand_blk();
         req1_valid = 1'b1;
         req1_data  = blk;
         @(negedge wclk);
         checks++; if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL hdr_ready[%0d]: got %b expected 1", b, req1_ready); end
         @(posedge wclk);
         #1;
         req1_valid = 1'b0;
         for (int k = 0; k <= NW; k++) begin
            @(negedge wclk);
            checks++;
            if (winc !== 1'b1 || wdata !== ((k == 0) ? hdr_exp[b] : blk[BW-1-(k-1)*DW -: DW])) begin
               errors++; $display("[TB] FAIL hdr_word[%0d][%0d]: got winc=%b %h", b, k, winc, wdata);
            end
         end
         @(posedge wclk);
         #1;
      end
   endtask
`endif

   task automatic test_random();
      logic [DW-1:0] expq[$];
      logic [7:0]    mseq[2];
      int  mlast, mleft, mgrant, win;
      bit  taken0, taken1;
      apply_reset();
      mlast   = 1;
      mleft   = 0;
      mgrant  = 0;
      mseq[0] = 8'h00;
      mseq[1] = 8'h00;
      taken0  = 1'b0;
      taken1  = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (taken0 || !req0_valid) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_data  = rand_blk();
         end
         if (taken1 || !req1_valid) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_data  = rand_blk();
         end
         wfull = ($urandom_range(0, 3) == 0);
         @(negedge wclk);
         taken0 = 1'b0;
         taken1 = 1'b0;
         if (mleft == 0) begin
            win = -1;
            if (req0_valid && req1_valid) win = (mlast == 1) ? 0 : 1;
            else if (req0_valid) win = 0;
            else if (req1_valid) win = 1;
            checks++;
            if (req0_ready !== (win == 0) || req1_ready !== (win == 1)) begin
               errors++; $display("[TB] FAIL rand_ready[%0d]: got %b%b expected winner %0d", cyc, req1_ready, req0_ready, win);
            end
            checks++; if (winc !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rand_idle[%0d]: got winc=%b busy=%b expected 0 0", cyc, winc, busy); end
            if (win >= 0) begin
               for (int k = 0; k < NWT; k++) begin
                  expq.push_back(exp_word(win == 1, (win == 1) ? req1_data : req0_data, mseq[win], k));
               end
               mseq[win] = mseq[win] + 8'h01;
               mleft  = NWT;
               mlast  = win;
               mgrant = win;
               taken0 = (win == 0);
               taken1 = (win == 1);
            end
         end else begin
            checks++;
            if ({req1_ready, req0_ready} !== 2'b00 || busy !== 1'b1 || grant_id !== (mgrant == 1)) begin
               errors++; $display("[TB] FAIL rand_send[%0d]: got ready=%b%b busy=%b grant_id=%b expected 00 1 %0d", cyc, req1_ready, req0_ready, busy, grant_id, mgrant);
            end
            checks++; if (winc !== !wfull) begin errors++; $display("[TB] FAIL rand_winc[%0d]: got %b expected %b", cyc, winc, !wfull); end
            if (!wfull) begin
               checks++;
               if (wdata !== expq[0]) begin errors++; $display("[TB] FAIL rand_wdata[%0d]: got %h expected %h", cyc, wdata, expq[0]); end
               void'(expq.pop_front());
               mleft--;
            end
         end
         @(posedge wclk);
         #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wfull      = 1'b0;
   endtask

   initial begin
      wrst_n     = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = '0;
      req1_data  = '0;
      wfull      = 1'b0;
      test_reset();
      test_single_block();
      test_contention();
      test_backpressure();
      test_wfull_toggle();
      test_reset_midblock();
`ifdef AES_FIFO_HDR_WORD_EN
      test_header();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
